// File: rtl/udma_rx_desc_seq.sv
// udma_rx_desc_seq: descriptor-queue sequencer that drives the cfg bus of a
// uDMA RX channel. (address, size) descriptors are queued in a small FIFO.
// The channel's CFG register is polled, and the next descriptor is written
// (SADDR, SIZE, CFG enable) whenever the channel's pending slot is free.
// An abort (clr_i) flushes the queue and writes the channel clear bit.
//
// Optional feature: define UDMA_RX_DESC_SEQ_TIMEOUT_EN to count polls that
// return pending = 1. After TIMEOUT_POLLS such polls the sticky err_o is
// raised, the queue is flushed and the channel is cleared. Without the macro
// the block polls forever and err_o is tied low.

module udma_rx_desc_seq #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int POLL_GAP       = 8,
    parameter int TIMEOUT_POLLS  = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          desc_valid_i,
    output logic                          desc_ready_o,
    input  logic [L2_AWIDTH_NOAL-1:0]     desc_addr_i,
    input  logic [TRANS_SIZE-1:0]         desc_size_i,
    input  logic                          continuous_i,
    input  logic                          clr_i,
    output logic [31:0]                   cfg_data_o,
    output logic [4:0]                    cfg_addr_o,
    output logic                          cfg_valid_o,
    output logic                          cfg_rwn_o,
    input  logic [31:0]                   cfg_data_i,
    input  logic                          cfg_ready_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          prog_evt_o,
    output logic                          err_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(POLL_GAP + 1);

    localparam logic [4:0] ADDR_SADDR = 5'h00;
    localparam logic [4:0] ADDR_SIZE  = 5'h01;
    localparam logic [4:0] ADDR_CFG   = 5'h02;

    typedef enum logic [2:0] {
        IDLE,
        POLL,
        GAP,
        WR_SADDR,
        WR_SIZE,
        WR_CFG,
        WR_CLR
    } state_e;

    state_e                    state_q;
    logic [L2_AWIDTH_NOAL-1:0] addr_mem_q [FIFO_DEPTH];
    logic [TRANS_SIZE-1:0]     size_mem_q [FIFO_DEPTH];
    logic [PW-1:0]             wptr_q;
    logic [PW-1:0]             rptr_q;
    logic [CW-1:0]             count_q;
    logic [CW-1:0]             count_d;
    logic                      clr_pend_q;
    logic [GW-1:0]             gap_cnt_q;

    logic                      cfg_valid_q;
    logic [4:0]                cfg_addr_q;
    logic                      cfg_rwn_q;
    logic [31:0]               cfg_data_q;
    logic                      prog_evt_q;

    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic                      cfg_done;
    logic                      poll_pending;
    logic                      timeout_hit;
    logic                      clr_req;
    logic                      clr_now;
    logic                      flush;

    logic                      req_rwn_d;
    logic [4:0]                req_addr_d;
    logic [31:0]               req_data_d;

    logic                      unused_cfg_data;

    // Only the pending bit of the CFG readback matters to the sequencer.
    assign unused_cfg_data = ^{cfg_data_i[31:6], cfg_data_i[4:0]};

    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign cfg_done     = cfg_valid_q & cfg_ready_i;
    assign poll_pending = (state_q == POLL) & cfg_done & cfg_data_i[5];

    // A flush request comes from an external abort or from a poll timeout;
    // clr_now also covers a flush that is already waiting for WR_CLR.
    assign clr_req      = clr_i | timeout_hit;
    assign clr_now      = clr_pend_q | clr_req;
    assign flush        = clr_req;

    assign desc_ready_o = ~full & ~clr_now;
    assign push         = desc_valid_i & desc_ready_o;
    assign pop          = (state_q == WR_CFG) & cfg_done & ~clr_now & ~empty;

    assign cfg_valid_o  = cfg_valid_q;
    assign cfg_addr_o   = cfg_addr_q;
    assign cfg_rwn_o    = cfg_rwn_q;
    assign cfg_data_o   = cfg_data_q;
    assign prog_evt_o   = prog_evt_q;
    assign fifo_count_o = count_q;
    assign busy_o       = (state_q != IDLE) | ~empty;

`ifdef UDMA_RX_DESC_SEQ_TIMEOUT_EN
    localparam int PCW = $clog2(TIMEOUT_POLLS + 1);

    logic [PCW-1:0] poll_cnt_q;
    logic           err_q;

    assign timeout_hit = poll_pending & (poll_cnt_q == PCW'(TIMEOUT_POLLS - 1));
    assign err_o       = err_q;

    // Count consecutive busy polls; restart when a descriptor gets programmed
    // and raise the sticky error once the limit is reached.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            poll_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (clr_i) begin
                poll_cnt_q <= '0;
                err_q      <= 1'b0;
            end else if (timeout_hit) begin
                poll_cnt_q <= '0;
            end else if (poll_pending) begin
                poll_cnt_q <= poll_cnt_q + PCW'(1);
            end else if ((state_q == POLL) && cfg_done && !clr_now) begin
                poll_cnt_q <= '0;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // Next occupancy of the descriptor FIFO; a push and a pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy, with a flush that empties the queue at once.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Descriptor storage; contents are don't-care until written by a push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wptr_q] <= desc_addr_i;
            size_mem_q[wptr_q] <= desc_size_i;
        end
    end

    // Bus request that the current state would issue (GAP prepares the poll).
    always_comb begin
        req_rwn_d  = 1'b0;
        req_addr_d = ADDR_SADDR;
        req_data_d = 32'h0;
        case (state_q)
            POLL, GAP: begin
                req_rwn_d  = 1'b1;
                req_addr_d = ADDR_CFG;
            end
            WR_SADDR: begin
                req_addr_d = ADDR_SADDR;
                req_data_d = 32'(addr_mem_q[rptr_q]);
            end
            WR_SIZE: begin
                req_addr_d = ADDR_SIZE;
                req_data_d = 32'(size_mem_q[rptr_q]);
            end
            WR_CFG: begin
                req_addr_d = ADDR_CFG;
                req_data_d = {26'h0, 1'b0, 1'b1, 3'b000, continuous_i};
            end
            WR_CLR: begin
                req_addr_d = ADDR_CFG;
                req_data_d = 32'h20;
            end
            default: begin
                req_rwn_d  = 1'b0;
                req_addr_d = ADDR_SADDR;
                req_data_d = 32'h0;
            end
        endcase
    end

    // Sequencer FSM with registered cfg bus outputs. A request is raised one
    // cycle after entering its state and held stable until the slave accepts;
    // a pending flush redirects to WR_CLR at the next transaction boundary.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_rwn_q   <= 1'b0;
            cfg_data_q  <= '0;
            prog_evt_q  <= 1'b0;
            gap_cnt_q   <= '0;
            clr_pend_q  <= 1'b0;
        end else begin
            prog_evt_q <= 1'b0;
            if (cfg_done) begin
                cfg_valid_q <= 1'b0;
            end
            if (clr_req) begin
                clr_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (clr_now) begin
                        state_q <= WR_CLR;
                    end else if (!empty) begin
                        state_q <= POLL;
                    end
                end

                POLL: begin
                    if (!cfg_valid_q) begin
                        if (clr_now) begin
                            state_q <= WR_CLR;
                        end else begin
                            cfg_valid_q <= 1'b1;
                            cfg_rwn_q   <= req_rwn_d;
                            cfg_addr_q  <= req_addr_d;
                            cfg_data_q  <= req_data_d;
                        end
                    end else if (cfg_ready_i) begin
                        if (clr_now) begin
                            state_q <= WR_CLR;
                        end else if (!cfg_data_i[5]) begin
                            state_q <= WR_SADDR;
                        end else begin
                            gap_cnt_q <= GW'(POLL_GAP);
                            state_q   <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (clr_now) begin
                        state_q <= WR_CLR;
                    end else if (gap_cnt_q <= GW'(1)) begin
                        gap_cnt_q   <= '0;
                        state_q     <= POLL;
                        cfg_valid_q <= 1'b1;
                        cfg_rwn_q   <= req_rwn_d;
                        cfg_addr_q  <= req_addr_d;
                        cfg_data_q  <= req_data_d;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end

                WR_SADDR, WR_SIZE, WR_CFG: begin
                    if (!cfg_valid_q) begin
                        if (clr_now) begin
                            state_q <= WR_CLR;
                        end else begin
                            cfg_valid_q <= 1'b1;
                            cfg_rwn_q   <= req_rwn_d;
                            cfg_addr_q  <= req_addr_d;
                            cfg_data_q  <= req_data_d;
                        end
                    end else if (cfg_ready_i) begin
                        if (state_q == WR_CFG) begin
                            prog_evt_q <= 1'b1;
                        end
                        if (clr_now) begin
                            state_q <= WR_CLR;
                        end else if (state_q == WR_SADDR) begin
                            state_q <= WR_SIZE;
                        end else if (state_q == WR_SIZE) begin
                            state_q <= WR_CFG;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end

                WR_CLR: begin
                    if (!cfg_valid_q) begin
                        cfg_valid_q <= 1'b1;
                        cfg_rwn_q   <= req_rwn_d;
                        cfg_addr_q  <= req_addr_d;
                        cfg_data_q  <= req_data_d;
                    end else if (cfg_ready_i) begin
                        if (!clr_req) begin
                            clr_pend_q <= 1'b0;
                        end
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
